// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the write-side packet framer.
//   framer_state_t : framer FSM states
//   len_w()        : width of a counter that can hold 0..max_pkt
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        SEND_HDR,
        SEND_PAY
    } framer_state_t;

    function automatic int len_w(input int max_pkt);
        return $clog2(max_pkt + 1);
    endfunction

endpackage

// File: rtl/pkt_buf.sv
// ---------------------------------------------------------------------------
// pkt_buf
// Packet payload store: DEPTH x DATA_WIDTH register array with one
// synchronous write port and one combinational read port. Not reset;
// contents are only meaningful for addresses written by the current packet.
// Ports:
//   wr_clk     in  : clock
//   i_we       in  : write enable
//   i_wrAddr   in  : write address
//   i_wrData   in  : write data
//   i_rdAddr   in  : read address
//   o_rdData   out : read data (combinational)
// ---------------------------------------------------------------------------
module pkt_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wr_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic [ADDR_WIDTH-1:0] i_rdAddr,
    output logic [DATA_WIDTH-1:0] o_rdData
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_pkt_framer.sv
// ---------------------------------------------------------------------------
// fifo_pkt_framer
// Write-side packet framer in front of a dual-clock FIFO. Collects one
// packet from a valid/ready byte stream, then writes a length header word
// followed by the payload into the FIFO, honouring fifo_full. Packets longer
// than MAX_PKT are discarded whole and counted.
// Ports:
//   wr_clk        in  : clock
//   rst_n         in  : asynchronous active-low reset
//   s_valid       in  : input beat valid
//   s_ready       out : framer can accept a beat
//   s_data        in  : input beat payload
//   s_last        in  : final beat of the packet
//   fifo_wr_data  out : word to FIFO (header, then payload)
//   fifo_wr_en    out : FIFO write strobe, never while fifo_full
//   fifo_full     in  : FIFO full flag
//   busy          out : framer is not idle
//   drop_pulse    out : one-cycle pulse per discarded packet
//   drop_cnt      out : saturating count of discarded packets
// ---------------------------------------------------------------------------
module fifo_pkt_framer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PKT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int LW = len_w(MAX_PKT);
    localparam int AW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

    // The header carries the length in one word, so MAX_PKT must fit.
    generate
        if (MAX_PKT < 1 || MAX_PKT > (2 ** DATA_WIDTH) - 1) begin : g_badMaxPkt
            $error("fifo_pkt_framer: MAX_PKT out of range 1..2^DATA_WIDTH-1");
        end
    endgenerate

    framer_state_t         r_state;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_idx;
    logic                  r_dropPulse;
    logic [CNT_WIDTH-1:0]  r_dropCnt;

    logic                  w_accept;
    logic                  w_collecting;
    logic                  w_full;
    logic                  w_bufWe;
    logic                  w_sending;
    logic                  w_lastPay;
    logic [AW-1:0]         w_wrAddr;
    logic [AW-1:0]         w_rdAddr;
    logic [DATA_WIDTH-1:0] w_rdData;

    assign s_ready      = (r_state == IDLE) || (r_state == COLLECT) || (r_state == DROP);
    assign w_accept     = s_valid && s_ready;
    assign w_collecting = (r_state == IDLE) || (r_state == COLLECT);
    assign w_full       = (r_len == LW'(MAX_PKT));
    assign w_bufWe      = w_accept && w_collecting && !w_full;
    assign w_sending    = (r_state == SEND_HDR) || (r_state == SEND_PAY);
    assign w_lastPay    = (r_idx == r_len - LW'(1));

    // r_len and r_idx never exceed MAX_PKT-1 when used as addresses.
    assign w_wrAddr = AW'(r_len);
    assign w_rdAddr = AW'(r_idx);

    pkt_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_PKT),
        .ADDR_WIDTH (AW)
    ) u_pktBuf (
        .wr_clk   (wr_clk),
        .i_we     (w_bufWe),
        .i_wrAddr (w_wrAddr),
        .i_wrData (s_data),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    // FIFO port is combinational so the FIFO samples it on the same edge
    // the framer advances; a stalled word simply stays on the bus.
    always_comb begin
        fifo_wr_en   = w_sending && !fifo_full;
        fifo_wr_data = '0;
        if (r_state == SEND_HDR) begin
            fifo_wr_data = DATA_WIDTH'(r_len);
        end else if (r_state == SEND_PAY) begin
            fifo_wr_data = w_rdData;
        end
    end

    assign busy       = (r_state != IDLE);
    assign drop_pulse = r_dropPulse;
    assign drop_cnt   = r_dropCnt;

    // Framer FSM with length/index counters and the drop statistics.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_dropPulse <= 1'b0;
            r_dropCnt   <= '0;
        end else begin
            r_dropPulse <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_accept) begin
                        if (!w_full) begin
                            r_len   <= r_len + LW'(1);
                            r_state <= s_last ? SEND_HDR : COLLECT;
                        end else if (s_last) begin
                            r_state     <= IDLE;
                            r_len       <= '0;
                            r_dropPulse <= 1'b1;
                            if (r_dropCnt != '1) begin
                                r_dropCnt <= r_dropCnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            r_state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (w_accept && s_last) begin
                        r_state     <= IDLE;
                        r_len       <= '0;
                        r_dropPulse <= 1'b1;
                        if (r_dropCnt != '1) begin
                            r_dropCnt <= r_dropCnt + CNT_WIDTH'(1);
                        end
                    end
                end
                SEND_HDR: begin
                    if (!fifo_full) begin
                        r_idx   <= '0;
                        r_state <= SEND_PAY;
                    end
                end
                SEND_PAY: begin
                    if (!fifo_full) begin
                        if (w_lastPay) begin
                            r_state <= IDLE;
                            r_len   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + LW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
